// File: rtl/csla_acc_stage.sv
// csla_acc_stage: burst accumulator built around a 32-bit carry-select adder.
// Operands stream in over a valid/ready handshake. Each burst, ended by in_last,
// is summed into one result that is held until the consumer takes it.
// Optional build macro CSLA_ACC_SATURATE_EN: the accumulator clamps to all-ones
// on carry-out instead of wrapping.

// Carry-select adder: BLK-bit blocks precompute both carry-in cases and a mux
// chain picks the right one, so only one block ripple sits on the carry path.
module csla32 #(
    parameter int BLK = 4
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    localparam int NB = 32 / BLK;

    logic [NB:0] carry;

    assign carry[0] = cin;

    for (genvar g = 0; g < NB; g++) begin : g_blk
        logic [BLK:0] s0, s1;
        // Both carry-in hypotheses for this block, computed in parallel
        always_comb begin
            s0 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
            s1 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
        end
        assign sum[g*BLK +: BLK] = carry[g] ? s1[BLK-1:0] : s0[BLK-1:0];
        assign carry[g+1]        = carry[g] ? s1[BLK]     : s0[BLK];
    end

    assign cout = carry[NB];
endmodule

module csla_acc_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);
    typedef enum logic {ST_ACC, ST_HOLD} state_t;

    state_t           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] add_sum;
    logic        add_cout;
    logic        accept;

    // The only adder on the datapath: accumulator plus incoming operand
    csla32 u_add (
        .a    (acc_q),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Next-state and handshake decode; ACC accepts operands, HOLD presents the result
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        in_ready  = (state_q == ST_ACC);
        out_valid = (state_q == ST_HOLD);
        accept    = in_valid && in_ready;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
`ifdef CSLA_ACC_SATURATE_EN
                    // Once saturated, any nonzero add carries out again, so it sticks
                    acc_d = add_cout ? 32'hFFFF_FFFF : add_sum;
`else
                    acc_d = add_sum;
`endif
                    ovf_d = ovf_q | add_cout;
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    if (in_last) state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    // State and datapath registers; reset drops any partial or pending result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign out_count = cnt_q;
endmodule

// File: tb/tb_csla_acc_stage.sv
// Scoreboard bench for csla_acc_stage. Two instances share all inputs: one with
// the default 8-bit counter, one with a 2-bit counter to reach count saturation.
module tb_csla_acc_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, out_ovf;
    logic        in_ready2, out_valid2, out_ovf2;
    logic [31:0] out_sum, out_sum2;
    logic [7:0]  out_count;
    logic [1:0]  out_count2;

    typedef struct {
        logic [31:0] sum;
        logic        ovf;
        logic [7:0]  cnt8;
        logic [1:0]  cnt2;
    } res_t;

    res_t q[$];
    res_t m;  // running model of the burst in progress
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    csla_acc_stage #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf),
        .out_count(out_count)
    );

    csla_acc_stage #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
        .out_ready(out_ready), .out_sum(out_sum2), .out_ovf(out_ovf2),
        .out_count(out_count2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m.sum = '0; m.ovf = 1'b0; m.cnt8 = '0; m.cnt2 = '0;
    endtask

    // Drive one beat (called at posedge+1), model it, and return at posedge+1
    task automatic beat(input logic [31:0] d, input logic last);
        logic [32:0] s;
        in_valid = 1'b1; in_data = d; in_last = last;
        @(negedge clk);
        chk("in_ready", in_ready, 1);
        s = {1'b0, m.sum} + {1'b0, d};
`ifdef CSLA_ACC_SATURATE_EN
        m.sum = s[32] ? 32'hFFFF_FFFF : s[31:0];
`else
        m.sum = s[31:0];
`endif
        m.ovf  = m.ovf | s[32];
        m.cnt8 = (m.cnt8 == 8'hFF) ? m.cnt8 : m.cnt8 + 8'd1;
        m.cnt2 = (m.cnt2 == 2'h3) ? m.cnt2 : m.cnt2 + 2'd1;
        if (last) begin
            q.push_back(m);
            model_clear();
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic chk_res(input string tag, input res_t e);
        chk({tag, "_sum"},  out_sum,    e.sum);
        chk({tag, "_ovf"},  out_ovf,    e.ovf);
        chk({tag, "_cnt"},  out_count,  e.cnt8);
        chk({tag, "_sum2"}, out_sum2,   e.sum);
        chk({tag, "_cnt2"}, out_count2, e.cnt2);
    endtask

    // Wait for a result, optionally stall it, take it and verify the clear
    task automatic collect(input int hold);
        res_t e;
        int   w = 0;
        @(negedge clk);
        while (!out_valid && w < 20) begin
            @(negedge clk); w++;
        end
        chk("latency", w, 0);
        if (q.size() == 0) begin
            chk("sb_empty", 1, 0);
            e.sum = '0; e.ovf = 1'b0; e.cnt8 = '0; e.cnt2 = '0;
        end else begin
            e = q.pop_front();
        end
        chk("out_valid2", out_valid2, 1);
        chk_res("res", e);
        if (hold > 0) begin
            out_ready = 1'b0;
            in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_valid", out_valid, 1);
                chk("hold_inrdy", in_ready, 0);
                chk_res("hold", e);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        chk("clr_valid", out_valid, 0);
        chk("clr_inrdy", in_ready, 1);
        chk("clr_sum", out_sum, 0);
        chk("clr_cnt", out_count, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        model_clear();
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_inrdy", in_ready, 1);
        chk("rst_sum", out_sum, 0);
        chk("rst_cnt", out_count, 0);
        chk("rst_ovf", out_ovf, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Idle with out_ready held: nothing may change
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_valid", out_valid, 0);
            chk("idle_inrdy", in_ready, 1);
            chk("idle_sum", out_sum, 0);
            chk("idle_cnt", out_count, 0);
        end
        @(posedge clk); #1;

        // Three-beat burst with out_ready high during ACC (must be ignored)
        beat(32'd5, 1'b0);
        beat(32'd10, 1'b0);
        beat(32'h1000_0000, 1'b1);
        out_ready = 1'b0;
        collect(0);

        // Wrap burst, then the same burst extended by one more beat
        beat(32'hFFFF_FFF0, 1'b0);
        beat(32'h20, 1'b1);
        collect(0);
        beat(32'hFFFF_FFF0, 1'b0);
        beat(32'h20, 1'b0);
        beat(32'h1, 1'b1);
        collect(0);

        // Single-beat burst under backpressure, then an independent burst
        beat(32'h1234_5678, 1'b1);
        collect(5);
        beat(32'd100, 1'b0);
        beat(32'd23, 1'b1);
        collect(0);

        // Reset pulsed between edges mid-burst
        beat(32'd7, 1'b0);
        beat(32'd9, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_sum", out_sum, 0);
        chk("mrst_cnt", out_count, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_inrdy", in_ready, 1);
        #1 rst_n = 1'b1;
        model_clear();
        @(posedge clk); #1;
        beat(32'd3, 1'b1);
        collect(0);

        // Five ones: narrow counter saturates at 3
        for (int i = 0; i < 5; i++) beat(32'd1, i == 4);
        collect(0);

        // Long random burst: saturates the 8-bit counter, exercises the adder
        for (int i = 0; i < 260; i++) beat($urandom, i == 259);
        collect(2);

        // Short random bursts
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 4; i++) beat($urandom, i == 3);
            collect(b % 2);
        end

        chk("sb_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
